multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that steps the shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and write-back cycles. It supports R-type, lw, sw, beq and j, and stalls on a memory ready handshake. It sits beside the datapath and drives every mux select and write enable each cycle.

---
 rtl/multicycle_control.sv | 159 +++++++++++++++
 tb/tb_multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/write-back and drives every select and enable.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOP,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [3:0] state_o,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam int unsigned OP_W = 6;
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
   } state_t;

   state_t state;

   // State sequencing; unused codes fall back to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:  if (mem_ready) state <= DECODE;
            DECODE: begin
               if ((opcode == OP_LW) || (opcode == OP_SW)) state <= MEMADR;
               else if (opcode == OP_RTYPE)                 state <= EXEC;
               else if (opcode == OP_BEQ)                   state <= BRANCH;
               else if (opcode == OP_J)                     state <= JUMP;
               else                                         state <= FETCH;
            end
            MEMADR: state <= (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWB:  state <= FETCH;
            MEMWR:  if (mem_ready) state <= FETCH;
            EXEC:   state <= RWB;
            RWB:    state <= FETCH;
            BRANCH: state <= FETCH;
            JUMP:   state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   // Control decode; reset masks everything so no strobe leaks while held.
   always_comb begin
      mem_req     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      ALUOP       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      state_o     = 4'd0;
      if (!reset) begin
         state_o = 4'(state);
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               if (!((opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                     (opcode == OP_BEQ) || (opcode == OP_J))) begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEMRD: begin
               mem_req = 1'b1;
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               mem_req    = 1'b1;
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               instr_done = mem_ready;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOP   = 2'b10;
            end
            RWB: begin
               RegWrite   = 1'b1;
               RegDst     = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOP       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               instr_done  = 1'b1;
            end
            JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = 2'b10;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-word checks.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
   logic [1:0] PCSource, ALUOP, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, MemtoReg, instr_done, illegal_op;
   logic [3:0] state_o;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .ALUOP(ALUOP), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .state_o(state_o), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

   // Control word: mem_req MemRead MemWrite IorD IRWrite PCWrite PCWriteCond
   //               PCSource[2] ALUOP[2] ALUSrcA ALUSrcB[2] RegWrite RegDst MemtoReg instr_done illegal_op
   localparam logic [18:0] C_ZERO     = 19'b0;
   localparam logic [18:0] C_FETCH_R  = {7'b1100110, 2'b00, 2'b00, 1'b0, 2'b01, 5'b00000};
   localparam logic [18:0] C_FETCH_S  = {7'b1100000, 2'b00, 2'b00, 1'b0, 2'b01, 5'b00000};
   localparam logic [18:0] C_DECODE   = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 5'b00000};
   localparam logic [18:0] C_DEC_ILL  = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 5'b00011};
   localparam logic [18:0] C_MEMADR   = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 5'b00000};
   localparam logic [18:0] C_MEMRD    = {7'b1101000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00000};
   localparam logic [18:0] C_MEMWB    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b10110};
   localparam logic [18:0] C_MEMWR_R  = {7'b1011000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00010};
   localparam logic [18:0] C_MEMWR_S  = {7'b1011000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b00000};
   localparam logic [18:0] C_EXEC     = {7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 5'b00000};
   localparam logic [18:0] C_RWB      = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 5'b11010};
   localparam logic [18:0] C_BRANCH   = {7'b0000001, 2'b01, 2'b01, 1'b1, 2'b00, 5'b00010};
   localparam logic [18:0] C_JUMP     = {7'b0000010, 2'b10, 2'b00, 1'b0, 2'b00, 5'b00010};

   function automatic logic [18:0] ctl_word();
      return {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
              PCSource, ALUOP, ALUSrcA, ALUSrcB, RegWrite, RegDst, MemtoReg,
              instr_done, illegal_op};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, sample mid-cycle on negedge, advance past posedge.
   task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                      input logic [3:0] exp_st, input logic [18:0] exp_ctl);
      opcode    = op;
      mem_ready = rdy;
      @(negedge clk);
      check({tag, "_st"}, 32'(state_o), 32'(exp_st));
      check({tag, "_ctl"}, 32'(ctl_word()), 32'(exp_ctl));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      opcode    = OP_R;
      mem_ready = 1'b1;
      @(negedge clk);
      check("reset_st", 32'(state_o), 32'd0);
      check("reset_ctl", 32'(ctl_word()), 32'(C_ZERO));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // R-type: 0,1,6,7
      cyc("r_f",  OP_R, 1'b1, 4'd0, C_FETCH_R);
      cyc("r_d",  OP_R, 1'b1, 4'd1, C_DECODE);
      cyc("r_ex", OP_R, 1'b1, 4'd6, C_EXEC);
      cyc("r_wb", OP_R, 1'b1, 4'd7, C_RWB);

      // lw with two MEMRD stall cycles: 0,1,2,3,3,3,4
      cyc("lw_f",   OP_LW, 1'b1, 4'd0, C_FETCH_R);
      cyc("lw_d",   OP_LW, 1'b1, 4'd1, C_DECODE);
      cyc("lw_a",   OP_LW, 1'b1, 4'd2, C_MEMADR);
      cyc("lw_rd0", OP_LW, 1'b0, 4'd3, C_MEMRD);
      cyc("lw_rd1", OP_LW, 1'b0, 4'd3, C_MEMRD);
      cyc("lw_rd2", OP_LW, 1'b1, 4'd3, C_MEMRD);
      cyc("lw_wb",  OP_LW, 1'b1, 4'd4, C_MEMWB);

      // sw with one FETCH stall: 0,0,1,2,5
      cyc("sw_f0", OP_SW, 1'b0, 4'd0, C_FETCH_S);
      cyc("sw_f1", OP_SW, 1'b1, 4'd0, C_FETCH_R);
      cyc("sw_d",  OP_SW, 1'b1, 4'd1, C_DECODE);
      cyc("sw_a",  OP_SW, 1'b1, 4'd2, C_MEMADR);
      cyc("sw_wr", OP_SW, 1'b1, 4'd5, C_MEMWR_R);

      // beq, with mem_ready low in non-memory states (must be ignored): 0,1,8
      cyc("beq_f", OP_BEQ, 1'b1, 4'd0, C_FETCH_R);
      cyc("beq_d", OP_BEQ, 1'b0, 4'd1, C_DECODE);
      cyc("beq_b", OP_BEQ, 1'b0, 4'd8, C_BRANCH);

      // j then illegal opcode: 0,1,9 then 0,1
      cyc("j_f",   OP_J,   1'b1, 4'd0, C_FETCH_R);
      cyc("j_d",   OP_J,   1'b1, 4'd1, C_DECODE);
      cyc("j_j",   OP_J,   1'b1, 4'd9, C_JUMP);
      cyc("ill_f", OP_BAD, 1'b1, 4'd0, C_FETCH_R);
      cyc("ill_d", OP_BAD, 1'b1, 4'd1, C_DEC_ILL);

      // sw stalled in MEMWR, then asynchronous reset mid-cycle
      cyc("rs_f",  OP_SW, 1'b1, 4'd0, C_FETCH_R);
      cyc("rs_d",  OP_SW, 1'b1, 4'd1, C_DECODE);
      cyc("rs_a",  OP_SW, 1'b1, 4'd2, C_MEMADR);
      mem_ready = 1'b0;
      @(negedge clk);
      check("rs_wr_st", 32'(state_o), 32'd5);
      check("rs_wr_ctl", 32'(ctl_word()), 32'(C_MEMWR_S));
      #1;
      reset = 1'b1;
      #1;
      check("rs_async_memwrite", 32'(MemWrite), 32'd0);
      check("rs_async_memreq", 32'(mem_req), 32'd0);
      check("rs_async_st", 32'(state_o), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("rs_post_f", OP_R, 1'b1, 4'd0, C_FETCH_R);
      cyc("rs_post_d", OP_R, 1'b1, 4'd1, C_DECODE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
